// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NREQ byte producers.
// A requester keeps the transmitter locked across a packet until it presents a byte with req_last set.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int DBIT         = 8,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic                 lock_timeout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   owner_r, owner_s;
  logic [PW-1:0]   winner_s, owner_next_s;
  logic            any_valid_s;
  logic [NREQ-1:0] grant_r, grant_s, ready_s;
  logic [DBIT-1:0] din_r, din_s;
  logic            last_r, last_s;
  logic            timeout_r, timeout_s;
  logic [CW-1:0]   hold_cnt_r, hold_cnt_s;

  assign owner_next_s = (owner_r == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1);

  // Round-robin search; scanning backwards leaves the first valid index from ptr as winner.
  always_comb begin
    any_valid_s = 1'b0;
    winner_s    = {PW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_r) + k) % NREQ]) begin
        any_valid_s = 1'b1;
        winner_s    = PW'((int'(ptr_r) + k) % NREQ);
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  // Next-state, accept decode and capture of the accepted byte.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    grant_s    = grant_r;
    din_s      = din_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    timeout_s  = 1'b0;
    ready_s    = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          ready_s[winner_s] = 1'b1;
          din_s             = req_data[int'(winner_s)*DBIT +: DBIT];
          last_s            = req_last[winner_s];
          owner_s           = winner_s;
          grant_s           = ONE_HOT0 << winner_s;
          state_s           = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick && last_r) begin
          grant_s = {NREQ{1'b0}};
          ptr_s   = owner_next_s;
          state_s = ST_IDLE;
        end else if (tx_done_tick) begin
          hold_cnt_s = {CW{1'b0}};
          state_s    = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // An accept in the last hold cycle wins over the timeout.
        if (req_valid[owner_r]) begin
          ready_s[owner_r] = 1'b1;
          din_s            = req_data[int'(owner_r)*DBIT +: DBIT];
          last_s           = req_last[owner_r];
          state_s          = ST_LOAD;
        end else if (hold_cnt_r == HOLD_LAST) begin
          timeout_s = 1'b1;
          grant_s   = {NREQ{1'b0}};
          ptr_s     = owner_next_s;
          state_s   = ST_IDLE;
        end else begin
          hold_cnt_s = hold_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {PW{1'b0}};
      owner_r    <= {PW{1'b0}};
      grant_r    <= {NREQ{1'b0}};
      din_r      <= {DBIT{1'b0}};
      last_r     <= 1'b0;
      timeout_r  <= 1'b0;
      hold_cnt_r <= {CW{1'b0}};
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      owner_r    <= owner_s;
      grant_r    <= grant_s;
      din_r      <= din_s;
      last_r     <= last_s;
      timeout_r  <= timeout_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

  // Masked during reset so no requester sees an accept while the arbiter is held.
  assign req_ready    = ready_s & {NREQ{~reset}};
  assign grant        = grant_r;
  assign tx_start     = (state_r == ST_LOAD);
  assign tx_din       = din_r;
  assign busy         = (state_r != ST_IDLE);
  assign lock_timeout = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, locking and timeout.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int DBIT = 8;
  localparam int HT   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        tx_start, tx_done_tick, busy, lock_timeout;
  logic [7:0]  tx_din;

  int n_tests = 0;
  int n_fail  = 0;

  // model of what the arbiter owes the outside world
  int         m_owner, m_ptr, m_gap, m_pick;
  bit         m_start_due, m_in_flight, m_last, m_timeout_due;
  logic [7:0] m_byte;

  logic [1:0] e_ready, e_grant, o_ready, o_grant;
  logic       e_start, e_busy, e_to, o_start, o_busy, o_to;
  logic [7:0] e_din, o_din;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done_tick(tx_done_tick), .busy(busy), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_gap = 0; m_pick = -1;
    m_start_due = 0; m_in_flight = 0; m_last = 0; m_timeout_due = 0;
    m_byte = 8'h00;
  endtask

  task automatic model_expect();
    m_pick = -1;
    if (reset) begin
      e_ready = 2'b00; e_grant = 2'b00; e_start = 1'b0;
      e_busy = 1'b0; e_to = 1'b0; e_din = 8'h00;
    end else begin
      if (m_start_due || m_in_flight) m_pick = -1;
      else if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++)
          if (m_pick < 0 && req_valid[(m_ptr + k) % NREQ]) m_pick = (m_ptr + k) % NREQ;
      end else if (req_valid[m_owner]) m_pick = m_owner;
      e_ready = (m_pick >= 0) ? (2'b01 << m_pick) : 2'b00;
      e_grant = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
      e_busy  = (m_owner >= 0);
      e_start = m_start_due;
      e_to    = m_timeout_due;
      e_din   = m_byte;
    end
  endtask

  task automatic model_advance();
    if (reset) model_reset();
    else begin
      m_timeout_due = 0;
      if (m_start_due) begin
        m_start_due = 0; m_in_flight = 1;
      end else if (m_in_flight) begin
        if (tx_done_tick) begin
          m_in_flight = 0;
          if (m_last) begin m_ptr = (m_owner + 1) % NREQ; m_owner = -1; end
          else m_gap = 0;
        end
      end else if (m_pick >= 0) begin
        m_byte = req_data[m_pick*DBIT +: DBIT];
        m_last = req_last[m_pick];
        m_owner = m_pick;
        m_start_due = 1;
      end else if (m_owner >= 0) begin
        if (m_gap == HT - 1) begin
          m_timeout_due = 1; m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
        end else m_gap++;
      end
    end
  endtask

  // Sample mid-cycle, step the model across the next edge, return just after it.
  task automatic tick();
    #1;
    model_expect();
    o_ready = req_ready; o_grant = grant; o_start = tx_start;
    o_din = tx_din; o_busy = busy; o_to = lock_timeout;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00; tx_done_tick = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = 2'($urandom); req_last = 2'($urandom);
      req_data = 16'($urandom); tx_done_tick = 1'($urandom);
      tick();
      n_tests++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", o_grant); end
      n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", o_start); end
      n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      n_tests++; if (o_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", o_ready); end
    end
    reset = 1'b0; req_valid = 2'b00; tx_done_tick = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++; if (o_busy !== 1'b0 || o_start !== 1'b0 || o_grant !== 2'b00)
        begin n_fail++; $display("FAIL reset_idle: got busy=%b start=%b grant=%b expected 0 0 00", o_busy, o_start, o_grant); end
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    req_valid = 2'b01; req_last = 2'b01; req_data = 16'h00A5;
    tick();
    n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", o_ready); end
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_start !== 1'b1 || o_din !== 8'hA5 || o_grant !== 2'b01)
      begin n_fail++; $display("FAIL single_load: got start=%b din=%h grant=%b expected 1 a5 01", o_start, o_din, o_grant); end
    req_valid = 2'b11;
    tick();
    n_tests++; if (o_ready !== 2'b00 || o_start !== 1'b0)
      begin n_fail++; $display("FAIL single_wait: got ready=%b start=%b expected 00 0", o_ready, o_start); end
    req_valid = 2'b00; tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tick();
    n_tests++; if (o_grant !== 2'b00 || o_busy !== 1'b0)
      begin n_fail++; $display("FAIL single_idle: got grant=%b busy=%b expected 00 0", o_grant, o_busy); end
    req_valid = 2'b11; req_data = 16'h3CA5;
    tick();
    n_tests++; if (o_ready !== 2'b10) begin n_fail++; $display("FAIL single_ptr: got %b expected 10", o_ready); end
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_din !== 8'h3C) begin n_fail++; $display("FAIL single_ptr_din: got %h expected 3c", o_din); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp_r;
    logic [7:0] exp_b;
    do_reset();
    req_valid = 2'b11; req_last = 2'b11; req_data = 16'h3C5A;
    for (int p = 0; p < 4; p++) begin
      exp_r = (p % 2 == 0) ? 2'b01 : 2'b10;
      exp_b = (p % 2 == 0) ? 8'h5A : 8'h3C;
      tick();
      n_tests++; if (o_ready !== exp_r) begin n_fail++; $display("FAIL contend_ready: got %b expected %b", o_ready, exp_r); end
      tick();
      n_tests++; if (o_start !== 1'b1 || o_din !== exp_b)
        begin n_fail++; $display("FAIL contend_byte: got start=%b din=%h expected 1 %h", o_start, o_din, exp_b); end
      tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    end
  endtask

  task automatic test_locked_burst();
    logic [7:0] burst [3];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    req_valid = 2'b10; req_data = 16'h1199; req_last = 2'b01;
    for (int b = 0; b < 3; b++) begin
      tick();
      n_tests++; if (o_ready !== 2'b10) begin n_fail++; $display("FAIL burst_accept: got %b expected 10", o_ready); end
      if (b < 2) begin
        req_data[15:8] = burst[b+1]; req_last[1] = (b + 1 == 2); req_valid = 2'b11;
      end else req_valid = 2'b01;
      tick();
      n_tests++; if (o_start !== 1'b1 || o_din !== burst[b] || o_ready !== 2'b00)
        begin n_fail++; $display("FAIL burst_byte: got start=%b din=%h ready=%b expected 1 %h 00", o_start, o_din, o_ready, burst[b]); end
      tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
      n_tests++; if (o_ready !== 2'b00) begin n_fail++; $display("FAIL burst_wait_ready: got %b expected 00", o_ready); end
    end
    tick();
    n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL burst_next_owner: got %b expected 01", o_ready); end
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_din !== 8'h99 || o_grant !== 2'b01)
      begin n_fail++; $display("FAIL burst_after: got din=%h grant=%b expected 99 01", o_din, o_grant); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 2'b01; req_data = 16'hEE77; req_last = 2'b10;
    tick();
    n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL to_accept: got %b expected 01", o_ready); end
    req_valid = 2'b10;
    tick();
    n_tests++; if (o_din !== 8'h77) begin n_fail++; $display("FAIL to_byte: got %h expected 77", o_din); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    for (int h = 0; h < HT; h++) begin
      tick();
      n_tests++; if (o_ready !== 2'b00 || o_to !== 1'b0 || o_grant !== 2'b01)
        begin n_fail++; $display("FAIL to_hold: cycle %0d got ready=%b to=%b grant=%b expected 00 0 01", h, o_ready, o_to, o_grant); end
    end
    tick();
    n_tests++; if (o_to !== 1'b1 || o_ready !== 2'b10 || o_grant !== 2'b00)
      begin n_fail++; $display("FAIL to_pulse: got to=%b ready=%b grant=%b expected 1 10 00", o_to, o_ready, o_grant); end
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_to !== 1'b0 || o_din !== 8'hEE || o_grant !== 2'b10)
      begin n_fail++; $display("FAIL to_after: got to=%b din=%h grant=%b expected 0 ee 10", o_to, o_din, o_grant); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_timeout_last_cycle_accept();
    do_reset();
    req_valid = 2'b01; req_data = 16'hEE77; req_last = 2'b10;
    tick();
    req_valid = 2'b10;
    tick();
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    for (int h = 0; h < HT - 1; h++) begin
      tick();
      n_tests++; if (o_to !== 1'b0 || o_ready !== 2'b00)
        begin n_fail++; $display("FAIL tolast_hold: cycle %0d got to=%b ready=%b expected 0 00", h, o_to, o_ready); end
    end
    req_valid = 2'b11; req_data = 16'hEE78; req_last = 2'b11;
    tick();
    n_tests++; if (o_ready !== 2'b01) begin n_fail++; $display("FAIL tolast_accept: got %b expected 01", o_ready); end
    req_valid = 2'b10;
    tick();
    n_tests++; if (o_din !== 8'h78 || o_to !== 1'b0 || o_start !== 1'b1)
      begin n_fail++; $display("FAIL tolast_byte: got din=%h to=%b start=%b expected 78 0 1", o_din, o_to, o_start); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    tick();
    n_tests++; if (o_to !== 1'b0 || o_ready !== 2'b10)
      begin n_fail++; $display("FAIL tolast_idle: got to=%b ready=%b expected 0 10", o_to, o_ready); end
    req_valid = 2'b00;
    tick();
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    req_valid = 2'b01; req_data = 16'h0FC3; req_last = 2'b11;
    tick();
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_din !== 8'hC3) begin n_fail++; $display("FAIL rstw_byte: got %h expected c3", o_din); end
    tick();
    n_tests++; if (o_grant !== 2'b01 || o_busy !== 1'b1)
      begin n_fail++; $display("FAIL rstw_wait: got grant=%b busy=%b expected 01 1", o_grant, o_busy); end
    reset = 1'b1;
    tick();
    n_tests++; if (o_start !== 1'b0 || o_grant !== 2'b00 || o_busy !== 1'b0 || o_din !== 8'h00)
      begin n_fail++; $display("FAIL rstw_reset: got start=%b grant=%b busy=%b din=%h expected 0 00 0 00", o_start, o_grant, o_busy, o_din); end
    reset = 1'b0; req_valid = 2'b10;
    tick();
    n_tests++; if (o_ready !== 2'b10) begin n_fail++; $display("FAIL rstw_accept: got %b expected 10", o_ready); end
    req_valid = 2'b00;
    tick();
    n_tests++; if (o_start !== 1'b1 || o_din !== 8'h0F || o_grant !== 2'b10)
      begin n_fail++; $display("FAIL rstw_new: got start=%b din=%h grant=%b expected 1 0f 10", o_start, o_din, o_grant); end
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL rstw_resend: got start=%b expected 0", o_start); end
    end
  endtask

  task automatic test_random();
    int frame_left;
    int prob;
    frame_left = 0;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      prob = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          req_valid[i] = (int'($urandom_range(0, 99)) < prob);
          req_last[i]  = 1'($urandom_range(0, 1));
        end
        req_data = 16'($urandom);
        reset = ($urandom_range(0, 299) == 0);
        if (frame_left > 0) begin
          frame_left--;
          tx_done_tick = (frame_left == 0);
        end else tx_done_tick = ($urandom_range(0, 19) == 0);
        tick();
        if (reset) frame_left = 0;
        else if (o_start) frame_left = int'($urandom_range(1, 5));
        n_tests++; if (o_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready: got %b expected %b", o_ready, e_ready); end
        n_tests++; if (o_grant !== e_grant) begin n_fail++; $display("FAIL rnd_grant: got %b expected %b", o_grant, e_grant); end
        n_tests++; if (o_start !== e_start) begin n_fail++; $display("FAIL rnd_start: got %b expected %b", o_start, e_start); end
        n_tests++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy: got %b expected %b", o_busy, e_busy); end
        n_tests++; if (o_to !== e_to) begin n_fail++; $display("FAIL rnd_timeout: got %b expected %b", o_to, e_to); end
        n_tests++; if (o_din !== e_din) begin n_fail++; $display("FAIL rnd_din: got %h expected %h", o_din, e_din); end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1; req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0000; tx_done_tick = 1'b0;
    test_reset();
    test_single_byte();
    test_contention();
    test_locked_burst();
    test_timeout();
    test_timeout_last_cycle_accept();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
